// File: rtl/mult_sequencer.sv
// Iterative radix-2 shift-add multiplier / multiply-accumulate sequencer for the execute stage.
// Holds the pipeline through stall_req while iterating and pulses done when the result is ready.
module mult_sequencer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter bit          EARLY_TERM = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      flush,
   input  logic                      signed_op,
   input  logic                      acc_en,
   input  logic [DATA_WIDTH-1:0]     op_a,
   input  logic [DATA_WIDTH-1:0]     op_b,
   input  logic [2*DATA_WIDTH-1:0]   acc_in,
   output logic [DATA_WIDTH-1:0]     result_lo,
   output logic [DATA_WIDTH-1:0]     result_hi,
   output logic                      busy,
   output logic                      stall_req,
   output logic                      done
);

   localparam int unsigned PW   = 2 * DATA_WIDTH;
   localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

   state_e                state_q, state_d;
   logic [PW-1:0]         product_q, product_d;
   logic [PW-1:0]         mcand_q, mcand_d;
   logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
   logic [CntW-1:0]       count_q, count_d;
   logic                  neg_q, neg_d;
   logic                  acc_en_q, acc_en_d;
   logic [PW-1:0]         acc_q, acc_d;
   logic [PW-1:0]         result_q, result_d;

   logic [DATA_WIDTH-1:0] a_mag, b_mag;
   logic [PW-1:0]         add_term;
   logic [PW-1:0]         fix_val;
   logic                  iter_last;

   always_comb begin
      state_d   = state_q;
      product_d = product_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      count_d   = count_q;
      neg_d     = neg_q;
      acc_en_d  = acc_en_q;
      acc_d     = acc_q;
      result_d  = result_q;
      stall_req = 1'b0;

      // Unsigned magnitude; the most negative value maps onto itself as an unsigned number.
      a_mag     = (signed_op && op_a[DATA_WIDTH-1]) ? -op_a : op_a;
      b_mag     = (signed_op && op_b[DATA_WIDTH-1]) ? -op_b : op_b;
      add_term  = mplier_q[0] ? mcand_q : '0;
      fix_val   = (neg_q ? -product_q : product_q) + (acc_en_q ? acc_q : '0);
      iter_last = (count_q == CntW'(DATA_WIDTH - 1)) ||
                  (EARLY_TERM && ((mplier_q >> 1) == '0));

      unique case (state_q)
         StIdle: begin
            if (start && !flush) begin
               stall_req = 1'b1;
               mcand_d   = {{DATA_WIDTH{1'b0}}, a_mag};
               mplier_d  = b_mag;
               neg_d     = signed_op & (op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1]);
               acc_en_d  = acc_en;
               acc_d     = acc_in;
               product_d = '0;
               count_d   = '0;
               state_d   = StIter;
            end
         end
         StIter: begin
            stall_req = 1'b1;
            product_d = product_q + add_term;
            mcand_d   = mcand_q << 1;
            mplier_d  = mplier_q >> 1;
            count_d   = count_q + CntW'(1);
            if (iter_last) state_d = StFix;
         end
         StFix: begin
            stall_req = 1'b1;
            result_d  = fix_val;
            state_d   = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Abort leaves the previously published result untouched.
      if (flush) begin
         state_d  = StIdle;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         product_q <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
         neg_q     <= 1'b0;
         acc_en_q  <= 1'b0;
         acc_q     <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         product_q <= product_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         count_q   <= count_d;
         neg_q     <= neg_d;
         acc_en_q  <= acc_en_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
      end
   end

   assign result_lo = result_q[DATA_WIDTH-1:0];
   assign result_hi = result_q[PW-1:DATA_WIDTH];
   assign busy      = (state_q == StIter) || (state_q == StFix);
   assign done      = (state_q == StDone);

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Iterative radix-2 shift-add multiply/multiply-accumulate controller and datapath beside the execute stage. It serves ARM7 MUL/MLA/UMULL/SMULL/UMLAL/SMLAL.
- Accepts operands on a single-cycle start and holds the pipeline via stall_req while iterating.
- Early termination on multiplier magnitude.
- Presents a 64-bit result with a one-cycle done pulse so the EX/MEM register captures it as the stall releases.

Parameters:
- DATA_WIDTH, 32, operand width; product, accumulator and result are 2*DATA_WIDTH.
- EARLY_TERM, 1, 1 = leave ITER once the remaining multiplier bits are all zero; 0 = always DATA_WIDTH iterations.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- flush  input  1  abort; highest priority after reset
- signed_op  input  1  1 = two's-complement operands (SMULL/SMLAL)
- acc_en  input  1  1 = add acc_in to the product
- op_a  input  DATA_WIDTH  multiplicand (Rm)
- op_b  input  DATA_WIDTH  multiplier (Rs)
- acc_in  input  2*DATA_WIDTH  accumulator {RdHi,RdLo}; the decoder zero-extends for MLA
- result_lo  output  DATA_WIDTH  product bits [DATA_WIDTH-1:0]
- result_hi  output  DATA_WIDTH  product bits [2*DATA_WIDTH-1:DATA_WIDTH]
- busy  output  1  state is ITER or FIX
- stall_req  output  1  pipeline stall request
- done  output  1  one-cycle pulse; result valid

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset values: state IDLE; result_lo/hi = 0; busy/stall_req/done = 0; internal product, multiplicand, multiplier, count, neg = 0.
- FSM states are IDLE, ITER, FIX, DONE.
- IDLE, start=1 and flush=0:
  - Latch mcand = |op_a| zero-extended to 2*DATA_WIDTH and mplier = |op_b|.
  - Magnitude is taken only when signed_op=1. |0x80000000| = 0x80000000 as unsigned.
  - Latch neg = signed_op & (op_a[MSB] ^ op_b[MSB]), acc_en and acc_in.
  - Clear product and count. Go to ITER.
- ITER, each cycle:
  - If mplier[0], product += mcand (mod 2^(2*DATA_WIDTH)).
  - Then mcand <<= 1, mplier >>= 1, count++.
  - Go to FIX when count == DATA_WIDTH-1, or when EARLY_TERM=1 and (mplier>>1) == 0.
- ITER length: N = DATA_WIDTH when EARLY_TERM=0. When EARLY_TERM=1, N = max(1, index of highest set bit of |op_b| + 1). op_b=0 gives N=1.
- FIX, one cycle:
  - Set result = (neg ? -product : product) + (acc_en ? acc : 0), truncated to 2*DATA_WIDTH.
  - Register into result_hi:result_lo. Go to DONE.
- DONE, one cycle: done=1, then go to IDLE. result holds until the next FIX writes it.
- stall_req = (IDLE & start & !flush) | ITER | FIX. It is combinational, and deasserts in DONE so the pipeline advances that cycle.
- Latency: start sampled in cycle T gives done in cycle T+N+2. stall_req is high for cycles T..T+N+1 (N+2 cycles).
- start outside IDLE is ignored and does not queue.
- flush in any state: next state IDLE, busy=0, no done, result unchanged.
  - stall_req drops combinationally in the flush cycle when in IDLE. Otherwise it drops the next cycle.
  - start and flush in the same cycle: flush wins, no operation begins.
- rst_n low mid-operation: immediate return to reset values; no done.
- The low word is identical for signed and unsigned operation. result_hi is always the full upper product.

Test Plan:
- Unsigned: a=7, b=6, acc_en=0, start at T -> N=3, done at T+5, result_hi:lo = 0x00000000_0000002A, stall_req high T..T+4.
- Worst case: a=b=0xFFFFFFFF, unsigned -> N=32, done at T+34, result_hi=0xFFFFFFFE, result_lo=0x00000001. With EARLY_TERM=0, a=7, b=6 -> done at T+34, result 0x2A.
- Signed: a=0xFFFFFFFD (-3), b=5, signed_op=1 -> done at T+5, result_hi:lo = 0xFFFFFFFF_FFFFFFF1. Repeat with a=5, b=-3 (|b|=3, N=2 -> done at T+4), same result.
- Accumulate: a=10, b=10, acc_en=1, acc_in=0x00000001_00000005 -> 0x00000001_00000069. b=0, acc_in=0x1234 -> N=1, done at T+3, result 0x1234.
- Flush at T+2 of a 7x6 after a prior result of 0x2A -> busy=0 at T+3, no done pulse, result stays 0x2A. A start asserted at T+1 (busy) is ignored. start+flush in the same cycle in IDLE -> stall_req=0, stays IDLE.
- rst_n pulsed low at T+2 -> outputs immediately zero, state IDLE. A new start after release completes normally with the correct result.
